// File: rtl/uart_report_pkg.sv
// Shared types, ASCII constants and nibble-to-character helper for the hex reporter.
package uart_report_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } report_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = ASCII_0 + {4'h0, nib};
        end else begin
            ch = ASCII_A + {4'h0, nib - 4'd10};
        end
        return ch;
    endfunction

endpackage

// File: rtl/uart_hex_reporter_if.sv
// Producer word handshake plus UART transmit handshake; master side is the reporter.
interface uart_hex_reporter_if #(
    parameter int unsigned WORD_W = 32
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              is_transmitting;
    logic              transmit;
    logic [7:0]        tx_byte;

    modport master (
        input  in_valid, in_data, is_transmitting,
        output in_ready, transmit, tx_byte
    );

    modport slave (
        output in_valid, in_data, is_transmitting,
        input  in_ready, transmit, tx_byte
    );
endinterface

// File: rtl/report_fifo.sv
// Synchronous word FIFO, first-word-fall-through: rd_data shows the head while not empty.
module report_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr, do_rd;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_hex_reporter.sv
// Drains queued result words to the UART as "<uppercase hex> CR LF", one byte per
// transmit/is_transmitting handshake, with ACK timeout retry and sticky error flag.
module uart_hex_reporter
    import uart_report_pkg::*;
#(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    uart_hex_reporter_if.master bus,
    output logic                busy,
    output logic                timeout_err
);
    localparam int unsigned NIB      = WORD_W / 4;
    localparam int unsigned LINE_LEN = NIB + 2;
    localparam int unsigned IDX_W    = $clog2(LINE_LEN);
    localparam int unsigned TO_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);
    localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NIB);

    report_state_e     state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  char_idx_q, char_idx_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic              fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_rd_data;

    assign bus.in_ready = !fifo_full && !reset;
    assign fifo_wr_en   = bus.in_valid && bus.in_ready;

    report_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr_en),
        .wr_data (bus.in_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        char_idx_d    = char_idx_q;
        tx_byte_d     = tx_byte_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
        fifo_rd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.is_transmitting) begin
                    fifo_rd_en = 1'b1;
                    word_d     = fifo_rd_data;
                    char_idx_d = '0;
                    tx_byte_d  = nib2ascii(fifo_rd_data[WORD_W-1 -: 4]);
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.is_transmitting) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    // tx_byte is left untouched so the retry resends the same character
                    if (to_cnt_d == TO_W'(ACK_TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_SEND;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.is_transmitting) begin
                    if (char_idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        char_idx_d = char_idx_q + 1'b1;
                        // the word is shifted so the next digit is always the top nibble
                        word_d     = word_q << 4;
                        state_d    = ST_SEND;
                        if (char_idx_d < CR_IDX) begin
                            tx_byte_d = nib2ascii(word_d[WORD_W-1 -: 4]);
                        end else if (char_idx_d == CR_IDX) begin
                            tx_byte_d = ASCII_CR;
                        end else begin
                            tx_byte_d = ASCII_LF;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            word_q        <= '0;
            char_idx_q    <= '0;
            tx_byte_q     <= '0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            char_idx_q    <= char_idx_d;
            tx_byte_q     <= tx_byte_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.transmit = (state_q == ST_SEND);
    assign bus.tx_byte  = tx_byte_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Self-checking bench: UART responder model, table of known lines, hand-written
// corner sequences and randomized word streams against a string-formatting model.
module tb_uart_hex_reporter;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned ACK_TIMEOUT = 15;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [31:0] word;
        int unsigned blen;
        string       text;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic timeout_err;

    uart_hex_reporter_if #(.WORD_W(WORD_W)) bus ();

    uart_hex_reporter #(
        .WORD_W      (WORD_W),
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // UART responder: accepts a pulse, stays busy busy_len cycles; can drop one chosen pulse.
    int unsigned busy_len   = 10;
    int          ignore_idx = -1;
    logic        stall      = 1'b0;
    int unsigned busy_left  = 0;
    int unsigned cyc        = 0;
    logic        prev_tx    = 1'b0;
    int unsigned hs_viol    = 0;
    logic [7:0]  rx_q [$];
    logic [7:0]  pl_byte [$];
    int unsigned pl_cyc [$];

    assign bus.is_transmitting = stall || (busy_left != 0);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_tx <= bus.transmit;
        if (bus.transmit && (bus.is_transmitting || prev_tx)) hs_viol <= hs_viol + 1;
        if (bus.transmit) begin
            if (int'(pl_byte.size()) != ignore_idx) begin
                rx_q.push_back(bus.tx_byte);
                busy_left <= busy_len;
            end
            pl_byte.push_back(bus.tx_byte);
            pl_cyc.push_back(cyc);
        end else if (busy_left != 0) begin
            busy_left <= busy_left - 1;
        end
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bytes(input string name, input int unsigned from, input byte_q_t exp);
        int          bad;
        int unsigned n;
        bad = -1;
        n   = (rx_q.size() > from) ? rx_q.size() - from : 0;
        checks++;
        for (int i = 0; i < exp.size() && i < int'(n); i++) begin
            if (rx_q[from + i] !== exp[i] && bad < 0) bad = i;
        end
        if (bad >= 0 || n != exp.size()) begin
            errors++;
            $display("FAIL %s: %0d bytes received, %0d expected, first bad index %0d got %02h expected %02h",
                     name, n, exp.size(), bad,
                     (bad >= 0) ? rx_q[from + bad] : 8'h00, (bad >= 0) ? exp[bad] : 8'h00);
        end
    endtask

    function automatic byte_q_t str_line(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    function automatic byte_q_t word_line(input logic [31:0] w);
        string s;
        s = $sformatf("%08h", w);
        s = s.toupper();
        return str_line(s);
    endfunction

    function automatic byte_q_t cat(input byte_q_t a, input byte_q_t b);
        byte_q_t q;
        q = a;
        foreach (b[i]) q.push_back(b[i]);
        return q;
    endfunction

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        logic acc;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < 3000; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check_val("push accepted", acc, 1'b1);
    endtask

    task automatic wait_idle(input string name, input int unsigned target);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (rx_q.size() >= target && !busy && !bus.is_transmitting) begin
                done = 1'b1;
                break;
            end
            cycles(1);
        end
        check_val(name, done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [5];
        byte_q_t     exp;
        logic [31:0] words [6];
        int unsigned r0, p0, p1, bad, err_cyc;
        logic        seen;

        vecs[0] = '{32'h1234ABCD, 10, "1234ABCD"};
        vecs[1] = '{32'h0A1B2C3D, 1,  "0A1B2C3D"};
        vecs[2] = '{32'hDEADBEEF, 3,  "DEADBEEF"};
        vecs[3] = '{32'h9876FEDC, 7,  "9876FEDC"};
        vecs[4] = '{32'h50F0A009, 2,  "50F0A009"};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        cycles(3);
        check_val("reset in_ready", bus.in_ready, 1'b0);
        check_val("reset transmit", bus.transmit, 1'b0);
        check_val("reset tx_byte", bus.tx_byte, 8'h00);
        check_val("reset busy", busy, 1'b0);
        check_val("reset timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        #1;
        check_val("in_ready after reset", bus.in_ready, 1'b1);
        cycles(1);

        for (int i = 0; i < 5; i++) begin
            busy_len = vecs[i].blen;
            r0 = rx_q.size();
            p0 = pl_byte.size();
            push(vecs[i].word);
            check_val($sformatf("idle on accept cycle[%0d]", i), bus.transmit, 1'b0);
            cycles(1);
            check_val($sformatf("latency[%0d]", i), bus.transmit, 1'b1);
            wait_idle($sformatf("line done[%0d]", i), r0 + 10);
            check_bytes($sformatf("line[%0d]", i), r0, str_line(vecs[i].text));
            check_val($sformatf("pulse count[%0d]", i), pl_byte.size() - p0, 10);
            bad = 0;
            for (int k = 1; k < 10; k++) begin
                if (pl_cyc[p0 + k] - pl_cyc[p0 + k - 1] != vecs[i].blen + 2) bad++;
            end
            check_val($sformatf("char spacing[%0d]", i), bad, 0);
        end

        // back-to-back lines: boundary costs exactly one IDLE cycle
        busy_len = 4;
        r0 = rx_q.size();
        p0 = pl_byte.size();
        push(32'h00000000);
        push(32'hFFFFFFFF);
        wait_idle("b2b done", r0 + 20);
        check_bytes("b2b lines", r0, cat(str_line("00000000"), str_line("FFFFFFFF")));
        check_val("b2b line gap", pl_cyc[p0 + 10] - pl_cyc[p0 + 9], busy_len + 3);

        // backpressure with the UART stalled
        busy_len = 3;
        stall    = 1'b1;
        r0 = rx_q.size();
        p0 = pl_byte.size();
        exp.delete();
        for (int i = 0; i < 6; i++) begin
            words[i] = $urandom;
            exp = cat(exp, word_line(words[i]));
        end
        for (int i = 0; i < 4; i++) push(words[i]);
        check_val("bp in_ready full", bus.in_ready, 1'b0);
        check_val("bp busy", busy, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = words[4];
        cycles(5);
        check_val("bp still full", bus.in_ready, 1'b0);
        check_val("bp no transmit", pl_byte.size() - p0, 0);
        stall = 1'b0;
        push(words[4]);
        push(words[5]);
        wait_idle("bp done", r0 + 60);
        check_bytes("bp order", r0, exp);

        // ACK timeout: first pulse dropped by the UART
        busy_len = 5;
        r0 = rx_q.size();
        p0 = pl_byte.size();
        check_val("timeout_err before", timeout_err, 1'b0);
        ignore_idx = int'(p0);
        push(32'hC0FFEE42);
        seen    = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (timeout_err) begin
                seen    = 1'b1;
                err_cyc = cyc;
                break;
            end
            cycles(1);
        end
        check_val("timeout seen", seen, 1'b1);
        wait_idle("timeout line done", r0 + 10);
        ignore_idx = -1;
        check_val("timeout rise delay", err_cyc - pl_cyc[p0], 16);
        check_val("retry delay", pl_cyc[p0 + 1] - pl_cyc[p0], 16);
        check_val("retry same char", pl_byte[p0 + 1], pl_byte[p0]);
        check_bytes("timeout line", r0, str_line("C0FFEE42"));
        check_val("timeout pulses", pl_byte.size() - p0, 11);
        check_val("timeout sticky", timeout_err, 1'b1);

        // reset during the third character of a two-word burst
        busy_len = 6;
        p0 = pl_byte.size();
        push(32'h11223344);
        push(32'h55667788);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (pl_byte.size() >= p0 + 3) begin
                seen = 1'b1;
                break;
            end
            cycles(1);
        end
        check_val("reached 3rd char", seen, 1'b1);
        reset = 1'b1;
        cycles(1);
        check_val("rst transmit", bus.transmit, 1'b0);
        check_val("rst busy", busy, 1'b0);
        check_val("rst in_ready", bus.in_ready, 1'b0);
        check_val("rst tx_byte", bus.tx_byte, 8'h00);
        check_val("rst timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        #1;
        check_val("rst in_ready release", bus.in_ready, 1'b1);
        cycles(1);
        p1 = pl_byte.size();
        cycles(150);
        check_val("rst no more bytes", pl_byte.size() - p1, 0);
        r0 = rx_q.size();
        push(32'h5A5A0F0F);
        wait_idle("post reset done", r0 + 10);
        check_bytes("post reset line", r0, str_line("5A5A0F0F"));

        // randomized streams with random producer gaps
        for (int b = 0; b < 3; b++) begin
            busy_len = $urandom_range(1, 12);
            r0 = rx_q.size();
            exp.delete();
            for (int k = 0; k < 8; k++) begin
                logic [31:0] w;
                w = $urandom;
                exp = cat(exp, word_line(w));
                push(w);
                cycles($urandom_range(0, 15));
            end
            wait_idle($sformatf("random done[%0d]", b), r0 + 80);
            check_bytes($sformatf("random stream[%0d]", b), r0, exp);
        end

        check_val("handshake violations", hs_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
